dst_tag_out_buffer_1x2: RTL and testbench
=========================================

DST_TAG_OUT_BUFFER_1X2 -- requirements
Module: dst_tag_out_buffer_1x2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width per branch.
REQ-002 SHALL have parameter CMD_WIDTH, default 1, residual command width per branch (upper-stage i_cmd minus one destination tag bit).
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, entries per branch, power of two and at least 2.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_en, input, 1, stage enable; when low, no push and no pop.
REQ-007 SHALL have port i_valid, input, 2, per-branch valid from the upstream 1x2 distribute stage; bit1 is high, bit0 is low.
REQ-008 SHALL have port i_data_bus, input, 2*DATA_WIDTH, where [2*DATA_WIDTH-1:DATA_WIDTH] is high and [DATA_WIDTH-1:0] is low.
REQ-009 SHALL have port i_cmd, input, 2*CMD_WIDTH, the per-branch residual command, upper half high.
REQ-010 SHALL have port o_ready, input-side output, 2, per-branch not-full indication to upstream.
REQ-011 SHALL have port o_valid, output, 2, per-branch head-entry valid.
REQ-012 SHALL have port o_data_bus, output, 2*DATA_WIDTH, per-branch head data, same packing as i_data_bus.
REQ-013 SHALL have port o_cmd, output, 2*CMD_WIDTH, per-branch head command, same packing as i_cmd.
REQ-014 SHALL have port i_ready, input, 2, per-branch downstream accept.

Function
REQ-015 SHALL run two independent FIFOs, one per branch, each storing {cmd, data}; there is no cross-branch coupling.
REQ-016 SHALL push branch b when i_en & i_valid[b] & o_ready[b].
REQ-017 SHALL drop a beat with i_en & i_valid[b] & ~o_ready[b] and leave the FIFO unchanged.
REQ-018 SHALL pop branch b when i_en & o_valid[b] & i_ready[b].
REQ-019 SHALL use first-word-fall-through: o_valid[b] = count[b] != 0, and o_data/o_cmd reflect the head entry combinationally from storage.
REQ-020 SHALL give 1-cycle latency: a push at edge N makes o_valid high after edge N when the FIFO was empty.
REQ-021 SHALL define o_ready[b] = count[b] < FIFO_DEPTH, with no dependency on same-cycle i_ready.
REQ-022 SHALL, on a simultaneous push and pop on a non-empty, non-full FIFO, leave count unchanged and advance both pointers.
REQ-023 SHALL, on a simultaneous push and pop when full, perform the pop only, because o_ready is low.
REQ-024 SHALL, on a simultaneous push and pop when empty, perform the push only.
REQ-025 SHALL use read/write pointers of width log2(FIFO_DEPTH) that wrap from FIFO_DEPTH-1 to 0; count has width log2(FIFO_DEPTH)+1 and saturates neither way.
REQ-026 SHALL drive o_data_bus and o_cmd to all zeros for a branch whose o_valid is low.
REQ-027 SHALL, while i_en is low, hold all state, with outputs still reflecting the current head.

Reset
REQ-028 SHALL asynchronously reset pointers and counts to 0 while rst_n is low, giving o_valid=2'b00, o_ready=2'b11, and zero data/cmd.
REQ-029 SHALL discard stored entries on reset mid-operation; storage contents need not be cleared.
REQ-030 SHALL apply the first push on the first rising edge after rst_n deasserts.

Configuration
REQ-031 SHALL, with macro DST_TAG_BUF_OVERFLOW_FLAG_EN defined, add output o_overflow [1:0], a per-branch sticky flag set on any dropped beat (REQ-017) and cleared only by reset.
REQ-032 SHALL, without DST_TAG_BUF_OVERFLOW_FLAG_EN, omit port o_overflow and its logic; drops stay silent.

Structure
REQ-033 SHALL place the defaults for DATA_WIDTH, CMD_WIDTH and FIFO_DEPTH, plus the branch index constants BR_HIGH=1 and BR_LOW=0, in the shared distribution-network package/header.
REQ-034 SHALL implement one sub-module, fifo_sync_fwft, parameterised on width and depth, instantiated twice.

Verification
REQ-035 SHALL cover: reset, then i_valid=2'b01, i_data low=32'hAAAAAAAA, i_cmd=2'b01 for one cycle -> o_valid=2'b01 next cycle, low data AAAAAAAA, o_cmd[0]=1.
REQ-036 SHALL cover: multicast i_valid=2'b11 with data BBBBBBBB on both branches and i_ready=2'b00 -> both branches valid with BBBBBBBB, and both held while i_ready stays low.
REQ-037 SHALL cover: 3 consecutive high-branch pushes with i_ready=0 at depth 2 -> o_ready[1]=0 after 2 pushes, the third is dropped, and with the macro o_overflow=2'b10.
REQ-038 SHALL cover: full high branch with i_ready[1]=1 and i_valid[1]=1 -> pop only, then refill next cycle, preserving order A, B, C across pointer wrap.
REQ-039 SHALL cover: i_en=0 with i_valid=2'b11 and i_ready=2'b11 -> no change in count or outputs.
REQ-040 SHALL cover: rst_n pulsed low asynchronously mid-stream with 1 entry per branch -> o_valid=0 and o_ready=2'b11 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dst_tag_out_buffer_1x2_pkg.sv
// Shared constants for the destination-tag distribution network.
// Holds default widths/depth and branch index constants.
package dst_tag_out_buffer_1x2_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int CMD_WIDTH_DEF  = 1;
  localparam int FIFO_DEPTH_DEF = 2;

  localparam int BR_HIGH = 1;
  localparam int BR_LOW  = 0;

  // Pointer width for a power-of-two depth; never below one bit.
  function automatic int ptr_width(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dst_tag_out_buffer_1x2_fifo_sync_fwft.sv
// Single-clock first-word-fall-through FIFO with enable-gated push/pop.
// Head entry is presented combinationally; empty head reads as zero.
module fifo_sync_fwft
  import dst_tag_out_buffer_1x2_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH_DEF + CMD_WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ready
);

  localparam int AW = ptr_width(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign wr_ready = (count < FULL_COUNT);
  assign rd_valid = (count != '0);

  // Full blocks push and empty blocks pop, so the corner cases fall out here.
  assign push = en & wr_valid & wr_ready;
  assign pop  = en & rd_valid & rd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage is deliberately left unreset; the count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = rd_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/dst_tag_out_buffer_1x2.sv
// Two-branch output buffer behind a 1x2 destination-tag distribute stage.
// Optional sticky drop flag o_overflow under DST_TAG_BUF_OVERFLOW_FLAG_EN.
module dst_tag_out_buffer_1x2
  import dst_tag_out_buffer_1x2_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CMD_WIDTH  = CMD_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic [1:0]              i_valid,
  input  logic [2*DATA_WIDTH-1:0] i_data_bus,
  input  logic [2*CMD_WIDTH-1:0]  i_cmd,
  output logic [1:0]              o_ready,
  output logic [1:0]              o_valid,
  output logic [2*DATA_WIDTH-1:0] o_data_bus,
  output logic [2*CMD_WIDTH-1:0]  o_cmd,
  input  logic [1:0]              i_ready
`ifdef DST_TAG_BUF_OVERFLOW_FLAG_EN
  ,
  output logic [1:0]              o_overflow
`endif
);

  localparam int EW = DATA_WIDTH + CMD_WIDTH;

  logic [1:0][EW-1:0] entry_in;
  logic [1:0][EW-1:0] entry_out;

  // Each entry is {cmd, data}; branches never interact.
  for (genvar b = 0; b < 2; b++) begin : g_pack
    assign entry_in[b] = {i_cmd[b*CMD_WIDTH +: CMD_WIDTH],
                          i_data_bus[b*DATA_WIDTH +: DATA_WIDTH]};
    assign o_data_bus[b*DATA_WIDTH +: DATA_WIDTH] = entry_out[b][DATA_WIDTH-1:0];
    assign o_cmd[b*CMD_WIDTH +: CMD_WIDTH]        = entry_out[b][EW-1:DATA_WIDTH];
  end

  fifo_sync_fwft #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo_high (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (i_en),
    .wr_valid (i_valid[BR_HIGH]),
    .wr_data  (entry_in[BR_HIGH]),
    .wr_ready (o_ready[BR_HIGH]),
    .rd_valid (o_valid[BR_HIGH]),
    .rd_data  (entry_out[BR_HIGH]),
    .rd_ready (i_ready[BR_HIGH])
  );

  fifo_sync_fwft #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo_low (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (i_en),
    .wr_valid (i_valid[BR_LOW]),
    .wr_data  (entry_in[BR_LOW]),
    .wr_ready (o_ready[BR_LOW]),
    .rd_valid (o_valid[BR_LOW]),
    .rd_data  (entry_out[BR_LOW]),
    .rd_ready (i_ready[BR_LOW])
  );

`ifdef DST_TAG_BUF_OVERFLOW_FLAG_EN
  logic [1:0] drop;

  assign drop = {2{i_en}} & i_valid & ~o_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_overflow <= '0;
    else        o_overflow <= o_overflow | drop;
  end
`endif

endmodule

// File: tb/tb_dst_tag_out_buffer_1x2.sv
// Bench for dst_tag_out_buffer_1x2: queue model compared every cycle plus
// directed literal checks.
module tb_dst_tag_out_buffer_1x2;

  localparam int DW    = 32;
  localparam int CW    = 1;
  localparam int DEPTH = 2;

  logic            clk;
  logic            rst_n;
  logic            i_en;
  logic [1:0]      i_valid;
  logic [2*DW-1:0] i_data_bus;
  logic [2*CW-1:0] i_cmd;
  logic [1:0]      o_ready;
  logic [1:0]      o_valid;
  logic [2*DW-1:0] o_data_bus;
  logic [2*CW-1:0] o_cmd;
  logic [1:0]      i_ready;
`ifdef DST_TAG_BUF_OVERFLOW_FLAG_EN
  logic [1:0]      o_overflow;
`endif

  int n_cmp = 0;
  int n_err = 0;

  dst_tag_out_buffer_1x2 #(
    .DATA_WIDTH (DW),
    .CMD_WIDTH  (CW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (i_en),
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .i_cmd      (i_cmd),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_data_bus (o_data_bus),
    .o_cmd      (o_cmd),
    .i_ready    (i_ready)
`ifdef DST_TAG_BUF_OVERFLOW_FLAG_EN
    ,
    .o_overflow (o_overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: one queue of {cmd,data} per branch, updated on each rising edge.
  logic [CW+DW-1:0] mq [2][$];
  logic [1:0]       m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq[0].delete();
      mq[1].delete();
      m_ovf = '0;
    end else if (i_en) begin
      for (int b = 0; b < 2; b++) begin
        automatic bit can_take = mq[b].size() < DEPTH;
        automatic bit has_head = mq[b].size() != 0;
        automatic logic [CW+DW-1:0] beat = {i_cmd[b*CW +: CW], i_data_bus[b*DW +: DW]};
        if (i_valid[b] && !can_take) m_ovf[b] = 1'b1;
        if (has_head && i_ready[b]) void'(mq[b].pop_front());
        if (i_valid[b] && can_take) mq[b].push_back(beat);
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0]      ev;
    logic [1:0]      er;
    logic [2*DW-1:0] ed;
    logic [2*CW-1:0] ec;
    ev = '0; er = '0; ed = '0; ec = '0;
    for (int b = 0; b < 2; b++) begin
      ev[b] = mq[b].size() != 0;
      er[b] = mq[b].size() < DEPTH;
      if (ev[b]) begin
        ed[b*DW +: DW] = mq[b][0][DW-1:0];
        ec[b*CW +: CW] = mq[b][0][DW +: CW];
      end
    end
    chk("model_valid", 64'(o_valid), 64'(ev));
    chk("model_ready", 64'(o_ready), 64'(er));
    chk("model_data",  64'(o_data_bus), 64'(ed));
    chk("model_cmd",   64'(o_cmd), 64'(ec));
`ifdef DST_TAG_BUF_OVERFLOW_FLAG_EN
    chk("model_ovf",   64'(o_overflow), 64'(m_ovf));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [1:0] vld, input logic [DW-1:0] dhi,
                       input logic [DW-1:0] dlo, input logic [1:0] cmd, input logic [1:0] rdy);
    i_en       = en;
    i_valid    = vld;
    i_data_bus = {dhi, dlo};
    i_cmd      = cmd;
    i_ready    = rdy;
  endtask

  logic [1:0] tv_valid [8];
  logic [1:0] tv_ready [8];

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 2'b00, '0, '0, 2'b00, 2'b00);
    repeat (3) @(posedge clk);
    #3;
    chk("rst_valid", 64'(o_valid), 64'h0);
    chk("rst_ready", 64'(o_ready), 64'h3);
    rst_n = 1'b1;
    chk("rst_data", o_data_bus, 64'h0);

    // single low-branch push
    drive(1'b1, 2'b01, 32'h0, 32'hAAAAAAAA, 2'b01, 2'b00);
    step();
    drive(1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 2'b00);
    chk("low_valid", 64'(o_valid), 64'h1);
    chk("low_data", o_data_bus, 64'h00000000_AAAAAAAA);
    chk("low_cmd", 64'(o_cmd), 64'h1);
    i_ready = 2'b01;
    step();
    i_ready = 2'b00;
    chk("low_drained", 64'(o_valid), 64'h0);

    // multicast, held while downstream stalls
    drive(1'b1, 2'b11, 32'hBBBBBBBB, 32'hBBBBBBBB, 2'b00, 2'b00);
    step();
    i_valid = 2'b00;
    chk("mc_valid", 64'(o_valid), 64'h3);
    chk("mc_data", o_data_bus, 64'hBBBBBBBB_BBBBBBBB);
    repeat (3) step();
    chk("mc_hold", o_data_bus, 64'hBBBBBBBB_BBBBBBBB);
    i_ready = 2'b11;
    step();
    i_ready = 2'b00;
    chk("mc_drained", 64'(o_valid), 64'h0);

    // fill high branch, third beat dropped
    drive(1'b1, 2'b10, 32'h1, 32'h0, 2'b00, 2'b00);
    step();
    chk("fill1_ready", 64'(o_ready), 64'h3);
    i_data_bus = {32'h2, 32'h0};
    step();
    chk("fill2_ready", 64'(o_ready), 64'h1);
    i_data_bus = {32'h3, 32'h0};
    step();
    i_valid = 2'b00;
    chk("fill3_ready", 64'(o_ready), 64'h1);
    chk("fill3_head", o_data_bus, 64'h00000001_00000000);
`ifdef DST_TAG_BUF_OVERFLOW_FLAG_EN
    chk("ovf_high", 64'(o_overflow), 64'h2);
`endif
    i_ready = 2'b10;
    step();
    chk("drain_head2", o_data_bus, 64'h00000002_00000000);
    step();
    i_ready = 2'b00;
    chk("drain_empty", 64'(o_valid), 64'h0);

    // full + push + pop, then refill across pointer wrap
    drive(1'b1, 2'b10, 32'hA, 32'h0, 2'b00, 2'b00);
    step();
    i_data_bus = {32'hB, 32'h0};
    step();
    chk("abc_headA", o_data_bus, 64'h0000000A_00000000);
    chk("abc_full", 64'(o_ready), 64'h1);
    drive(1'b1, 2'b10, 32'hC, 32'h0, 2'b00, 2'b10);
    step();
    chk("abc_headB", o_data_bus, 64'h0000000B_00000000);
    chk("abc_popOnly", 64'(o_ready), 64'h3);
    step();
    chk("abc_headC", o_data_bus, 64'h0000000C_00000000);
    chk("abc_validC", 64'(o_valid), 64'h2);
    i_valid = 2'b00;
    step();
    i_ready = 2'b00;
    chk("abc_empty", 64'(o_valid), 64'h0);

    // enable low freezes everything
    drive(1'b1, 2'b11, 32'h11111111, 32'h22222222, 2'b10, 2'b00);
    step();
    drive(1'b0, 2'b11, 32'h33333333, 32'h44444444, 2'b01, 2'b11);
    repeat (2) step();
    chk("en0_valid", 64'(o_valid), 64'h3);
    chk("en0_data", o_data_bus, 64'h11111111_22222222);
    chk("en0_cmd", 64'(o_cmd), 64'h2);
    chk("en0_ready", 64'(o_ready), 64'h3);
    drive(1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 2'b00);

    // asynchronous reset mid-cycle with one entry per branch
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(o_valid), 64'h0);
    chk("arst_ready", 64'(o_ready), 64'h3);
    chk("arst_data", o_data_bus, 64'h0);
`ifdef DST_TAG_BUF_OVERFLOW_FLAG_EN
    chk("arst_ovf", 64'(o_overflow), 64'h0);
`endif
    #2 rst_n = 1'b1;
    drive(1'b1, 2'b01, 32'h0, 32'h55555555, 2'b00, 2'b00);
    step();
    i_valid = 2'b00;
    chk("first_push", 64'(o_valid), 64'h1);
    chk("first_data", o_data_bus, 64'h00000000_55555555);

    // mixed traffic, checked by the model every cycle
    tv_valid[0] = 2'b11; tv_ready[0] = 2'b00;
    tv_valid[1] = 2'b10; tv_ready[1] = 2'b01;
    tv_valid[2] = 2'b11; tv_ready[2] = 2'b11;
    tv_valid[3] = 2'b01; tv_ready[3] = 2'b10;
    tv_valid[4] = 2'b11; tv_ready[4] = 2'b00;
    tv_valid[5] = 2'b11; tv_ready[5] = 2'b00;
    tv_valid[6] = 2'b00; tv_ready[6] = 2'b11;
    tv_valid[7] = 2'b10; tv_ready[7] = 2'b11;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, tv_valid[i], 32'hC0DE0000 + 32'(i), 32'hF00D0000 + 32'(i),
            2'(i), tv_ready[i]);
      step();
    end
    drive(1'b1, 2'b00, '0, '0, 2'b00, 2'b11);
    repeat (3) step();
    chk("final_empty", 64'(o_valid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
